// File: rtl/ex_result_buffer_pkg.sv
//------------------------------------------------------------------------------
// Module  : ex_result_buffer_pkg
// Brief   : Shared branch-condition encodings, entry record and branch helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ex_result_buffer_pkg;

    localparam logic [2:0] c_brEq  = 3'b000;
    localparam logic [2:0] c_brNe  = 3'b001;
    localparam logic [2:0] c_brLt  = 3'b100;
    localparam logic [2:0] c_brGe  = 3'b101;
    localparam logic [2:0] c_brLtu = 3'b110;
    localparam logic [2:0] c_brGeu = 3'b111;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken_A;
        logic        taken_B;
    } entry_t;

    // One lane's branch decision; the reserved encodings 010/011 never take.
    function automatic logic evalCond(input logic [2:0] cond, input logic eq,
                                      input logic slt, input logic ult);
        logic taken;
        taken = 1'b0;
        case (cond)
            c_brEq:  taken = eq;
            c_brNe:  taken = !eq;
            c_brLt:  taken = slt;
            c_brGe:  taken = !slt;
            c_brLtu: taken = ult;
            c_brGeu: taken = !ult;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_result_buffer_br_resolve.sv
//------------------------------------------------------------------------------
// Module  : br_resolve
// Brief   : Combinational per-lane branch outcome evaluation at the push side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module br_resolve
    import ex_result_buffer_pkg::*;
(
    input  logic       i_mode,
    input  logic       i_brEn,
    input  logic [2:0] i_brCond,
    input  logic       i_eqA,
    input  logic       i_sltA,
    input  logic       i_ultA,
    input  logic       i_eqB,
    input  logic       i_sltB,
    input  logic       i_ultB,
    output logic       o_takenA,
    output logic       o_takenB
);

    always_comb begin
        o_takenA = 1'b0;
        o_takenB = 1'b0;
        if (i_brEn) begin
            o_takenA = evalCond(i_brCond, i_eqA, i_sltA, i_ultA);
            // Lane B only exists in split mode.
            o_takenB = !i_mode && evalCond(i_brCond, i_eqB, i_sltB, i_ultB);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_result_buffer.sv
//------------------------------------------------------------------------------
// Module  : ex_result_buffer
// Brief   : DEPTH-entry FIFO of ALU results with branch outcomes resolved at push.
//           Optional macro EX_RESULT_FWD_EN adds a youngest-writer forward port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_result_buffer
    import ex_result_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic        in_mode,
    input  logic        in_eqA,
    input  logic        in_sltA,
    input  logic        in_ultA,
    input  logic        in_eqB,
    input  logic        in_sltB,
    input  logic        in_ultB,
    input  logic        in_br_en,
    input  logic [2:0]  in_br_cond,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_br_taken_A,
    output logic        out_br_taken_B
`ifdef EX_RESULT_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [63:0] fwd_data
`endif
);

    localparam int c_ptrW = $clog2(DEPTH);
    localparam int c_cntW = c_ptrW + 1;

    entry_t              r_mem [DEPTH];
    logic [c_ptrW-1:0]   r_wrPtr;
    logic [c_ptrW-1:0]   r_rdPtr;
    logic [c_cntW-1:0]   r_count;

    logic   w_takenA;
    logic   w_takenB;
    logic   w_push;
    logic   w_pop;
    entry_t w_entry;
    entry_t w_head;

    br_resolve u_brResolve (
        .i_mode   (in_mode),
        .i_brEn   (in_br_en),
        .i_brCond (in_br_cond),
        .i_eqA    (in_eqA),
        .i_sltA   (in_sltA),
        .i_ultA   (in_ultA),
        .i_eqB    (in_eqB),
        .i_sltB   (in_sltB),
        .i_ultB   (in_ultB),
        .o_takenA (w_takenA),
        .o_takenB (w_takenB)
    );

    // Handshakes depend only on stored count, never on the consumer's ready.
    assign in_ready  = !rst && (r_count < c_cntW'(DEPTH));
    assign out_valid = !rst && (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_comb begin
        w_entry         = '0;
        w_entry.result  = in_result;
        w_entry.rd      = in_rd;
        w_entry.we      = in_we;
        w_entry.taken_A = w_takenA;
        w_entry.taken_B = w_takenB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_entry;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_head         = r_mem[r_rdPtr];
    assign out_result     = out_valid ? w_head.result  : '0;
    assign out_rd         = out_valid ? w_head.rd      : '0;
    assign out_we         = out_valid ? w_head.we      : 1'b0;
    assign out_br_taken_A = out_valid ? w_head.taken_A : 1'b0;
    assign out_br_taken_B = out_valid ? w_head.taken_B : 1'b0;

`ifdef EX_RESULT_FWD_EN
    logic [c_ptrW-1:0] w_idx;

    // Walk oldest to youngest so the last matching writer wins.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rdPtr + c_ptrW'(i);
            if (!rst && (c_cntW'(i) < r_count) && r_mem[w_idx].we) begin
                fwd_valid = 1'b1;
                fwd_rd    = r_mem[w_idx].rd;
                fwd_data  = r_mem[w_idx].result;
            end
        end
    end
`endif

endmodule

`default_nettype wire
